// File: rtl/fpu_pkg.sv
// Shared FP-unit definitions: sizing constants, latency type and major opcodes.
package fpu_pkg;

    localparam int unsigned NREG    = 32;   // FP architectural registers
    localparam int unsigned MAX_LAT = 5;    // hazard vector width / max latency class
    localparam int unsigned CW      = 3;    // latency counter width, 2**CW > MAX_LAT
    localparam int unsigned RW      = 5;    // register specifier width
    localparam int unsigned STAT_W  = 32;   // hazard statistics counter width

    typedef logic [CW-1:0]      lat_t;
    typedef logic [MAX_LAT-1:0] hazard_t;

    // RISC-V major opcodes that route to the FP unit
    localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
    localparam logic [6:0] OPC_FMADD    = 7'b1000011;
    localparam logic [6:0] OPC_FMSUB    = 7'b1000111;
    localparam logic [6:0] OPC_FNMSUB   = 7'b1001011;
    localparam logic [6:0] OPC_FNMADD   = 7'b1001111;
    localparam logic [6:0] OPC_OP_FP    = 7'b1010011;

endpackage

// File: rtl/fpu_lat_decode.sv
// Thermometer hazard vector to latency: counts the run of ones starting at bit 0.
// Ones above the first zero are ignored. Purely combinational.
module fpu_lat_decode
    import fpu_pkg::*;
(
    input  hazard_t hazard,
    output lat_t    lat
);

    logic run;

    // Latency is the index just past the last bit of the unbroken low run
    always_comb begin
        lat = '0;
        run = 1'b1;
        for (int k = 0; k < int'(MAX_LAT); k++) begin
            run = run & hazard[k];
            if (run) lat = lat_t'(k + 1);
        end
    end

endmodule

// File: rtl/fpu_issue_scoreboard.sv
// FP issue-stage scoreboard: per-register pending-latency counters plus a
// writeback-slot reservation ring; stalls on RAW, WAW and write-port conflicts.
// Optional hazard statistics counters are built when FPU_SB_STATS_EN is defined.
module fpu_issue_scoreboard
    import fpu_pkg::*;
(
    input  logic          clk,
    input  logic          rstn,
    input  logic          flush,
    input  logic          hold,
    input  logic          iss_valid,
    input  logic [RW-1:0] rd,
    input  logic [RW-1:0] rs1,
    input  logic [RW-1:0] rs2,
    input  logic [RW-1:0] rs3,
    input  logic          use_rs1,
    input  logic          use_rs2,
    input  logic          use_rs3,
    input  logic          reg_write,
    input  hazard_t       hazard,
    output logic          stall,
    output logic          issue,
    output logic          busy
`ifdef FPU_SB_STATS_EN
   ,output logic [STAT_W-1:0] stat_raw,
    output logic [STAT_W-1:0] stat_waw,
    output logic [STAT_W-1:0] stat_sth
`endif
);

    localparam int unsigned RES_W = MAX_LAT + 1;

    lat_t             lat;
    lat_t             cnt [NREG];
    logic [RES_W-1:0] res;
    logic [RES_W-1:0] res_sh;
    logic [RES_W-1:0] res_set;
    logic             raw;
    logic             waw;
    logic             sth;
    logic             wr_issue;

    fpu_lat_decode u_lat_decode (
        .hazard (hazard),
        .lat    (lat)
    );

    // Hazard terms and issue decision; res_sh[1] is res[L+1], zero past the top
    always_comb begin
        raw      = (use_rs1 && (cnt[rs1] != '0)) ||
                   (use_rs2 && (cnt[rs2] != '0)) ||
                   (use_rs3 && (cnt[rs3] != '0));
        waw      = reg_write && (cnt[rd] != '0);
        res_sh   = res >> lat;
        sth      = reg_write && res_sh[1];
        stall    = iss_valid && (raw || waw || sth);
        issue    = iss_valid && !stall && !hold && !flush;
        wr_issue = issue && reg_write;
        res_set  = wr_issue ? (RES_W'(1) << lat) : '0;
    end

    // Anything still in flight keeps the unit busy
    always_comb begin
        busy = |res;
        for (int i = 0; i < int'(NREG); i++) begin
            busy = busy | (cnt[i] != '0);
        end
    end

    // Age counters and shift the ring; a new writer's latency overrides its decrement
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            res <= '0;
            for (int i = 0; i < int'(NREG); i++) cnt[i] <= '0;
        end else if (flush) begin
            res <= '0;
            for (int i = 0; i < int'(NREG); i++) cnt[i] <= '0;
        end else if (!hold) begin
            res <= (res >> 1) | res_set;
            for (int i = 0; i < int'(NREG); i++) begin
                if (wr_issue && (lat != '0) && (rd == RW'(i))) begin
                    cnt[i] <= lat;
                end else if (cnt[i] != '0) begin
                    cnt[i] <= cnt[i] - lat_t'(1);
                end
            end
        end
    end

`ifdef FPU_SB_STATS_EN
    // Saturating per-term stall counters; survive flush, cleared only by reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_raw <= '0;
            stat_waw <= '0;
            stat_sth <= '0;
        end else begin
            if (stall && raw && (stat_raw != '1)) stat_raw <= stat_raw + STAT_W'(1);
            if (stall && waw && (stat_waw != '1)) stat_waw <= stat_waw + STAT_W'(1);
            if (stall && sth && (stat_sth != '1)) stat_sth <= stat_sth + STAT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fpu_issue_scoreboard.sv
// Self-checking bench for fpu_issue_scoreboard. The reference model tracks, in
// logical (non-held) time, the cycle each register becomes ready and the set of
// reserved writeback cycles. Define FPU_SB_STATS_EN to also check the counters.
module tb_fpu_issue_scoreboard;

    logic       clk = 1'b0;
    logic       rstn, flush, hold, iss_valid;
    logic [4:0] rd, rs1, rs2, rs3;
    logic       use_rs1, use_rs2, use_rs3, reg_write;
    logic [4:0] hazard;
    logic       stall, issue, busy;
`ifdef FPU_SB_STATS_EN
    logic [31:0] stat_raw, stat_waw, stat_sth;
`endif

    fpu_issue_scoreboard dut (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .hold      (hold),
        .iss_valid (iss_valid),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .rs3       (rs3),
        .use_rs1   (use_rs1),
        .use_rs2   (use_rs2),
        .use_rs3   (use_rs3),
        .reg_write (reg_write),
        .hazard    (hazard),
        .stall     (stall),
        .issue     (issue),
        .busy      (busy)
`ifdef FPU_SB_STATS_EN
       ,.stat_raw  (stat_raw),
        .stat_waw  (stat_waw),
        .stat_sth  (stat_sth)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int ready_at [32];   // logical cycle at which the register stops blocking
    bit wb [int];        // logical cycles with a reserved writeback
    int lt = 0;          // logical time: advances on edges without hold/flush
    int m_raw = 0, m_waw = 0, m_sth = 0;

    typedef struct {
        bit v;
        logic [4:0] d, s1, s2, s3;
        bit u1, u2, u3, w;
        logic [4:0] hz;
        bit hold, flush;
    } op_t;

    function automatic op_t mk(bit v, logic [4:0] d, s1, s2, s3,
                               bit u1, u2, u3, w, logic [4:0] hz);
        op_t o;
        o.v = v; o.d = d; o.s1 = s1; o.s2 = s2; o.s3 = s3;
        o.u1 = u1; o.u2 = u2; o.u3 = u3; o.w = w; o.hz = hz;
        o.hold = 1'b0; o.flush = 1'b0;
        return o;
    endfunction

    function automatic op_t idle_op();
        return mk(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    endfunction

    task automatic drive(input op_t o);
        iss_valid = o.v;  rd = o.d; rs1 = o.s1; rs2 = o.s2; rs3 = o.s3;
        use_rs1 = o.u1; use_rs2 = o.u2; use_rs3 = o.u3;
        reg_write = o.w; hazard = o.hz; hold = o.hold; flush = o.flush;
    endtask

    function automatic int lat_of(logic [4:0] h);
        int n = 0;
        for (int k = 0; k < 5; k++) begin
            if (h[k]) n++;
            else break;
        end
        return n;
    endfunction

    task automatic model_clear();
        foreach (ready_at[i]) ready_at[i] = 0;
        wb.delete();
    endtask

    // Expected outputs for the inputs currently applied
    task automatic model_eval(output bit e_stall, e_issue, e_busy, r, ww, st);
        int L;
        L  = lat_of(hazard);
        r  = (use_rs1 && ready_at[rs1] > lt) || (use_rs2 && ready_at[rs2] > lt) ||
             (use_rs3 && ready_at[rs3] > lt);
        ww = reg_write && (ready_at[rd] > lt);
        st = reg_write && wb.exists(lt + L + 1);
        e_stall = iss_valid && (r || ww || st);
        e_issue = iss_valid && !e_stall && !hold && !flush;
        e_busy  = 1'b0;
        foreach (ready_at[i]) if (ready_at[i] > lt) e_busy = 1'b1;
        foreach (wb[k]) if (k >= lt) e_busy = 1'b1;
    endtask

    // Advance one clock and move the model along with it
    task automatic tick();
        bit es, ei, eb, r, ww, st;
        int L;
        model_eval(es, ei, eb, r, ww, st);
        L = lat_of(hazard);
        if (es) begin
            m_raw += int'(r); m_waw += int'(ww); m_sth += int'(st);
        end
        @(posedge clk);
        if (flush) begin
            model_clear();
        end else if (!hold) begin
            if (ei && reg_write) begin
                if (L > 0) ready_at[rd] = lt + L + 1;
                wb[lt + L + 1] = 1'b1;
            end
            lt++;
            if (wb.exists(lt - 1)) wb.delete(lt - 1);
        end
        @(negedge clk);
    endtask

    task automatic quiesce();
        drive(idle_op());
        repeat (8) tick();
    endtask

    task automatic test_reset();
        drive(idle_op());
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %b, expected 0", stall); end
        n_checks++;
        if (issue !== 1'b0) begin n_errors++; $display("FAIL reset_issue: got %b, expected 0", issue); end
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_raw();
        op_t p, c;
        bit es, ei, eb, r, ww, st;
        int first = -1;
        p = mk(1'b1, 5'd3, 5'd1, 5'd2, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1, 5'b01111);
        c = mk(1'b1, 5'd6, 5'd3, 5'd8, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'b01111);
        for (int t = 0; t < 8; t++) begin
            drive((t == 0) ? p : ((first < 0) ? c : idle_op()));
            #1;
            model_eval(es, ei, eb, r, ww, st);
            if (t > 0 && first < 0 && ei) first = t;
            n_checks++;
            if ({stall, issue, busy} !== {es, ei, eb}) begin
                n_errors++;
                $display("FAIL raw t=%0d: stall/issue/busy got %b%b%b, expected %b%b%b",
                         t, stall, issue, busy, es, ei, eb);
            end
            tick();
        end
        n_checks++;
        if (first != 5) begin n_errors++; $display("FAIL raw_issue_cycle: got T+%0d, expected T+5", first); end
`ifdef FPU_SB_STATS_EN
        n_checks++;
        if ({stat_raw, stat_waw, stat_sth} !== {32'd4, 32'd0, 32'd0}) begin
            n_errors++;
            $display("FAIL raw_stats: got raw=%0d waw=%0d sth=%0d, expected 4 0 0",
                     stat_raw, stat_waw, stat_sth);
        end
`endif
        quiesce();
    endtask

    task automatic test_waw();
        op_t p, c;
        bit es, ei, eb, r, ww, st;
        int first = -1;
        p = mk(1'b1, 5'd5, 5'd9, 5'd10, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'b00011);
        c = mk(1'b1, 5'd5, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'b00011);
        for (int t = 0; t < 6; t++) begin
            drive((t == 0) ? p : ((first < 0) ? c : idle_op()));
            #1;
            model_eval(es, ei, eb, r, ww, st);
            if (t > 0 && first < 0 && ei) first = t;
            n_checks++;
            if ({stall, issue, busy} !== {es, ei, eb}) begin
                n_errors++;
                $display("FAIL waw t=%0d: stall/issue/busy got %b%b%b, expected %b%b%b",
                         t, stall, issue, busy, es, ei, eb);
            end
            tick();
        end
        n_checks++;
        if (first != 3) begin n_errors++; $display("FAIL waw_issue_cycle: got T+%0d, expected T+3", first); end
        quiesce();
    endtask

    task automatic test_struct();
        op_t p, c;
        bit es, ei, eb, r, ww, st;
        p = mk(1'b1, 5'd1, 5'd11, 5'd12, 5'd13, 1'b1, 1'b1, 1'b1, 1'b1, 5'b01111);
        c = mk(1'b1, 5'd2, 5'd14, 5'd15, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'b00011);
        for (int g = 2; g >= 1; g--) begin
            int first = -1;
            for (int t = 0; t < 6; t++) begin
                drive((t == 0) ? p : ((t >= g && first < 0) ? c : idle_op()));
                #1;
                model_eval(es, ei, eb, r, ww, st);
                if (t >= g && first < 0 && ei) first = t;
                n_checks++;
                if ({stall, issue, busy} !== {es, ei, eb}) begin
                    n_errors++;
                    $display("FAIL struct g=%0d t=%0d: stall/issue/busy got %b%b%b, expected %b%b%b",
                             g, t, stall, issue, busy, es, ei, eb);
                end
                tick();
            end
            n_checks++;
            if (first != ((g == 2) ? 3 : 1)) begin
                n_errors++;
                $display("FAIL struct_issue_cycle g=%0d: got T+%0d, expected T+%0d",
                         g, first, (g == 2) ? 3 : 1);
            end
            quiesce();
        end
    endtask

    task automatic test_hold();
        op_t p, c;
        bit es, ei, eb, r, ww, st;
        int first = -1;
        p = mk(1'b1, 5'd4, 5'd16, 5'd17, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'b00001);
        c = mk(1'b1, 5'd18, 5'd4, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'b00001);
        for (int t = 0; t < 8; t++) begin
            op_t o;
            o = (t == 0) ? p : ((first < 0) ? c : idle_op());
            o.hold = (t >= 1 && t <= 3);
            drive(o);
            #1;
            model_eval(es, ei, eb, r, ww, st);
            if (t > 0 && first < 0 && ei) first = t;
            n_checks++;
            if ({stall, issue, busy} !== {es, ei, eb}) begin
                n_errors++;
                $display("FAIL hold t=%0d: stall/issue/busy got %b%b%b, expected %b%b%b",
                         t, stall, issue, busy, es, ei, eb);
            end
            if (t >= 1 && t <= 3) begin
                n_checks++;
                if ({stall, issue} !== 2'b10) begin
                    n_errors++;
                    $display("FAIL hold_frozen t=%0d: stall/issue got %b%b, expected 10", t, stall, issue);
                end
            end
            tick();
        end
        n_checks++;
        if (first <= 3) begin n_errors++; $display("FAIL hold_issue: got T+%0d, expected after T+3", first); end
        quiesce();
    endtask

    // mode 0: flush at T+1; mode 1: asynchronous reset pulse at T+1
    task automatic test_flush_reset();
        op_t p, c, f;
        bit es, ei, eb, r, ww, st;
        p = mk(1'b1, 5'd7, 5'd20, 5'd21, 5'd22, 1'b1, 1'b1, 1'b1, 1'b1, 5'b01111);
        c = mk(1'b1, 5'd23, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'b00001);
        for (int mode = 0; mode < 2; mode++) begin
            drive(p);
            tick();
            f = idle_op();
            f.flush = (mode == 0);
            drive(f);
            #1;
            n_checks++;
            if (busy !== 1'b1) begin n_errors++; $display("FAIL flush_busy_before m=%0d: got %b, expected 1", mode, busy); end
            if (mode == 1) begin
                #1 rstn = 1'b0;
                model_clear();
                m_raw = 0; m_waw = 0; m_sth = 0;
                #2 rstn = 1'b1;
            end
            tick();
            drive(c);
            #1;
            model_eval(es, ei, eb, r, ww, st);
            n_checks++;
            if ({stall, issue, busy} !== {es, ei, eb}) begin
                n_errors++;
                $display("FAIL flush_model m=%0d: stall/issue/busy got %b%b%b, expected %b%b%b",
                         mode, stall, issue, busy, es, ei, eb);
            end
            n_checks++;
            if ({issue, busy} !== 2'b10) begin
                n_errors++;
                $display("FAIL flush_consumer m=%0d: issue/busy got %b%b, expected 10", mode, issue, busy);
            end
            tick();
            quiesce();
        end
    endtask

    task automatic test_random();
        bit es, ei, eb, r, ww, st;
        for (int t = 0; t < 600; t++) begin
            op_t o;
            int n;
            o = mk($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom), 5'($urandom));
            n = $urandom_range(0, 5);
            if ($urandom_range(0, 1) == 0) o.hz = 5'((32'd1 << n) - 32'd1);
            o.hold  = ($urandom_range(0, 9) == 0);
            o.flush = ($urandom_range(0, 29) == 0);
            drive(o);
            #1;
            model_eval(es, ei, eb, r, ww, st);
            n_checks++;
            if ({stall, issue, busy} !== {es, ei, eb}) begin
                n_errors++;
                $display("FAIL random t=%0d: stall/issue/busy got %b%b%b, expected %b%b%b",
                         t, stall, issue, busy, es, ei, eb);
            end
            tick();
        end
        quiesce();
    endtask

    initial begin
        drive(idle_op());
        rstn = 1'b0;
        model_clear();
        test_reset();
        test_raw();
        test_waw();
        test_struct();
        test_hold();
        test_flush_reset();
        test_random();
`ifdef FPU_SB_STATS_EN
        n_checks++;
        if ({stat_raw, stat_waw, stat_sth} !== {32'(m_raw), 32'(m_waw), 32'(m_sth)}) begin
            n_errors++;
            $display("FAIL stats_final: got raw=%0d waw=%0d sth=%0d, expected %0d %0d %0d",
                     stat_raw, stat_waw, stat_sth, m_raw, m_waw, m_sth);
        end
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
